// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller: FSM state encoding and travel direction.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-request register with clear-on-service, plus detection of requests
// above and below the current floor.
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter int NFLR = 4,
  parameter int CURW = $clog2(NFLR)
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [NFLR-1:0] req,
  input  logic [CURW-1:0] cur,
  input  logic            clr,
  input  logic [CURW-1:0] clr_idx,
  output logic [NFLR-1:0] pend,
  output logic [NFLR-1:0] eff,
  output logic            above,
  output logic            below
);

  logic [NFLR-1:0] clr_mask;

  always_comb begin
    eff      = pend | req;
    clr_mask = '0;
    if (clr) clr_mask[clr_idx] = 1'b1;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NFLR; i++) begin
      if (i > int'(cur)) above = above | eff[i];
      if (i < int'(cur)) below = below | eff[i];
    end
  end

  // Clearing the floor being entered or dwelt at also keeps Req[cur] out of Pend during DOOR.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) pend <= '0;
    else       pend <= eff & ~clr_mask;
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: IDLE/MOVE/DOOR FSM with travel counter and
// door dwell timer; pending requests live in elevator_req_reg.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NFLR     = 4,
  parameter int DOOR_CYC = 4,
  parameter int MOVE_CYC = 2
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [NFLR-1:0] Req,
  input  logic            Blk,
  output logic [NFLR-1:0] Floor,
  output logic            Door,
  output logic            Moving,
  output logic            Dir,
  output logic [NFLR-1:0] Pend
);

  localparam int CURW    = $clog2(NFLR);
  localparam int CNT_MAX = (DOOR_CYC > MOVE_CYC) ? DOOR_CYC : MOVE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   MOVE_LD = CW'(MOVE_CYC - 1);
  localparam logic [CW-1:0]   DOOR_LD = CW'(DOOR_CYC - 1);
  localparam logic [CURW-1:0] TOP     = CURW'(NFLR - 1);

  state_t          state, state_n;
  logic [CURW-1:0] cur, cur_n;
  logic            dir, dir_n;
  logic [CW-1:0]   mcnt, mcnt_n;
  logic [CW-1:0]   dtmr, dtmr_n;
  logic [NFLR-1:0] eff;
  logic            above, below;
  logic            ahead, behind, at_end;

  elevator_req_reg #(.NFLR(NFLR), .CURW(CURW)) u_req (
    .clk    (clk),
    .Reset  (Reset),
    .req    (Req),
    .cur    (cur),
    .clr    (state_n == DOOR),
    .clr_idx(cur_n),
    .pend   (Pend),
    .eff    (eff),
    .above  (above),
    .below  (below)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cur   <= '0;
      dir   <= DIR_UP;
      mcnt  <= '0;
      dtmr  <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      dir   <= dir_n;
      mcnt  <= mcnt_n;
      dtmr  <= dtmr_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    dir_n   = dir;
    mcnt_n  = mcnt;
    dtmr_n  = dtmr;
    ahead   = (dir == DIR_UP) ? above : below;
    behind  = (dir == DIR_UP) ? below : above;
    at_end  = (dir == DIR_UP) ? (cur == TOP) : (cur == '0);
    unique case (state)
      IDLE: begin
        if (eff[cur]) begin
          state_n = DOOR;
          dtmr_n  = DOOR_LD;
        end else if (ahead) begin
          state_n = MOVE;
          mcnt_n  = MOVE_LD;
        end else if (behind) begin
          state_n = MOVE;
          mcnt_n  = MOVE_LD;
          dir_n   = ~dir;
        end
      end
      MOVE: begin
        if (mcnt != '0) begin
          mcnt_n = mcnt - 1'b1;
        end else if (at_end) begin
          // Unreachable while a target is latched; guards cur against stepping off the shaft.
          state_n = IDLE;
        end else begin
          cur_n = (dir == DIR_UP) ? cur + 1'b1 : cur - 1'b1;
          if (eff[cur_n]) begin
            state_n = DOOR;
            dtmr_n  = DOOR_LD;
          end else begin
            mcnt_n = MOVE_LD;
          end
        end
      end
      DOOR: begin
        if (Blk || Req[cur])  dtmr_n  = DOOR_LD;
        else if (dtmr == '0)  state_n = IDLE;
        else                  dtmr_n  = dtmr - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign Floor  = {{(NFLR-1){1'b0}}, 1'b1} << cur;
  assign Door   = (state == DOOR);
  assign Moving = (state == MOVE);
  assign Dir    = dir;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed and randomized bench for elevator_ctrl against a remaining-cycles
// behavioural model of the car.
module tb_elevator_ctrl;

  localparam int NFLR     = 4;
  localparam int DOOR_CYC = 4;
  localparam int MOVE_CYC = 2;

  logic            clk = 1'b0;
  logic            Reset;
  logic [NFLR-1:0] Req;
  logic            Blk;
  logic [NFLR-1:0] Floor;
  logic            Door;
  logic            Moving;
  logic            Dir;
  logic [NFLR-1:0] Pend;

  elevator_ctrl #(.NFLR(NFLR), .DOOR_CYC(DOOR_CYC), .MOVE_CYC(MOVE_CYC)) dut (
    .clk   (clk),
    .Reset (Reset),
    .Req   (Req),
    .Blk   (Blk),
    .Floor (Floor),
    .Door  (Door),
    .Moving(Moving),
    .Dir   (Dir),
    .Pend  (Pend)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Model: phase 0 = parked, 1 = travelling, 2 = door open; m_left = edges until the phase event.
  int m_phase;
  int m_floor;
  bit m_up;
  int m_left;
  bit m_pend [NFLR];

  task automatic model_reset();
    m_phase = 0;
    m_floor = 0;
    m_up    = 1'b1;
    m_left  = 0;
    for (int i = 0; i < NFLR; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input logic [NFLR-1:0] r, input logic b);
    bit e [NFLR];
    bit fwd, back;
    for (int i = 0; i < NFLR; i++) e[i] = m_pend[i] | r[i];
    case (m_phase)
      0: begin
        if (e[m_floor]) begin
          m_phase = 2; m_left = DOOR_CYC; e[m_floor] = 1'b0;
        end else begin
          fwd = 1'b0; back = 1'b0;
          for (int i = 0; i < NFLR; i++) begin
            if (m_up ? (i > m_floor) : (i < m_floor)) fwd = fwd | e[i];
            else if (i != m_floor)                    back = back | e[i];
          end
          if (fwd) begin
            m_phase = 1; m_left = MOVE_CYC;
          end else if (back) begin
            m_phase = 1; m_left = MOVE_CYC; m_up = !m_up;
          end
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          if (e[m_floor]) begin
            m_phase = 2; m_left = DOOR_CYC; e[m_floor] = 1'b0;
          end else begin
            m_left = MOVE_CYC;
          end
        end
      end
      default: begin
        e[m_floor] = 1'b0;
        if (b || r[m_floor]) m_left = DOOR_CYC;
        else begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      end
    endcase
    for (int i = 0; i < NFLR; i++) m_pend[i] = e[i];
  endtask

  task automatic chk(input string tag, input logic [NFLR-1:0] obs, input logic [NFLR-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NFLR-1:0] ef, ep;
    ef = '0;
    ef[m_floor] = 1'b1;
    for (int i = 0; i < NFLR; i++) ep[i] = m_pend[i];
    chk("floor",  Floor,        ef);
    chk("door",   4'(Door),     4'(m_phase == 2));
    chk("moving", 4'(Moving),   4'(m_phase == 1));
    chk("dir",    4'(Dir),      4'(m_up));
    chk("pend",   Pend,         ep);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(Req, Blk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse(input logic [NFLR-1:0] r);
    Req = r;
    tick();
    Req = '0;
  endtask

  // Reset raised and dropped between two edges; outputs must clear without a clock.
  task automatic async_reset_pulse();
    #3 Reset = 1'b1;
    #1;
    model_reset();
    chk("rst_floor",  Floor,      4'b0001);
    chk("rst_door",   4'(Door),   4'b0000);
    chk("rst_moving", 4'(Moving), 4'b0000);
    chk("rst_pend",   Pend,       4'b0000);
    chk("rst_dir",    4'(Dir),    4'b0001);
    #2 Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    Req   = '0;
    Blk   = 1'b0;
    model_reset();
    #2;
    chk("init_floor",  Floor,      4'b0001);
    chk("init_door",   4'(Door),   4'b0000);
    chk("init_moving", 4'(Moving), 4'b0000);
    chk("init_dir",    4'(Dir),    4'b0001);
    chk("init_pend",   Pend,       4'b0000);
    @(negedge clk);
    Reset = 1'b0;

    // Call at the current floor.
    pulse(4'b0001);
    ticks(6);
    // Up-call to the top floor.
    pulse(4'b1000);
    ticks(12);
    // Return to the ground floor.
    pulse(4'b0001);
    ticks(12);
    // Intermediate stop on the way up, then a call behind the car.
    pulse(4'b1000);
    pulse(4'b0010);
    ticks(2);
    pulse(4'b0001);
    ticks(30);
    // Door held by obstruction from the second open cycle.
    pulse(4'b0001);
    tick();
    Blk = 1'b1;
    ticks(6);
    Blk = 1'b0;
    ticks(8);
    // Re-request at the current floor in the last open cycle.
    pulse(4'b0001);
    ticks(3);
    pulse(4'b0001);
    ticks(6);
    // Reset while travelling past floor 2.
    pulse(4'b1000);
    ticks(4);
    chk("mid_move_floor", Floor, 4'b0100);
    async_reset_pulse();
    ticks(3);

    for (int n = 0; n < 400; n++) begin
      Req = ($urandom_range(0, 3) == 0) ? NFLR'($urandom_range(0, 15)) : '0;
      Blk = ($urandom_range(0, 9) == 0);
      tick();
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
    end
    Req = '0;
    Blk = 1'b0;
    ticks(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NFLR, default 4, number of floors (>=2).
REQ-002 Parameter DOOR_CYC, default 4, door-open dwell in clock cycles (>=1).
REQ-003 Parameter MOVE_CYC, default 2, travel time per floor in clock cycles (>=1).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Req  in  NFLR  call requests, bit i = floor i; any number of bits may be set; sampled every edge.
REQ-007 Blk  in  1  door obstruction, 1 = blocked.
REQ-008 Floor  out  NFLR  one-hot current floor.
REQ-009 Door  out  1  door open.
REQ-010 Moving  out  1  car travelling between floors.
REQ-011 Dir  out  1  travel direction, 1 = up, 0 = down.
REQ-012 Pend  out  NFLR  latched pending requests.

Function
REQ-013 States SHALL be IDLE, MOVE and DOOR; Door = (state==DOOR); Moving = (state==MOVE); Floor = 1 << cur, where cur is a $clog2(NFLR)-bit index.
REQ-014 The effective request vector E SHALL be Pend | Req; Pend <= E each edge, except as stated in REQ-015 and REQ-019.
REQ-015 The Pend bit for cur SHALL clear on the edge that enters DOOR.
REQ-016 IDLE decisions, in priority order:
- E[cur] -> DOOR.
- Any E bit beyond cur in Dir -> MOVE, Dir held.
- Any E bit in the opposite direction -> MOVE, Dir flipped on the same edge.
- Otherwise remain IDLE.
REQ-017 MOVE entry SHALL load the travel counter with MOVE_CYC-1; the counter decrements each cycle; at the edge where it is 0, cur steps +1 (Dir=1) or -1 (Dir=0).
REQ-018 On each arrival, if E[new cur] -> DOOR, else MOVE continues with the counter reloaded; Dir SHALL NOT change in MOVE.
REQ-019 DOOR entry SHALL load the door timer with DOOR_CYC-1.
- Blk=1, or Req[cur]=1, reloads the timer; Req[cur] is not latched into Pend while in DOOR.
- At timer==0 with Blk=0 and Req[cur]=0 -> IDLE.
REQ-020 cur SHALL never move below 0 or above NFLR-1; at either end the REQ-016 search finds nothing further in Dir and reverses.
REQ-021 Requests arriving during MOVE SHALL be latched and served at the first matching arrival in the current Dir; requests behind the car wait for reversal.
REQ-022 Counter width SHALL be $clog2(max(DOOR_CYC,MOVE_CYC)+1); no arithmetic wrap is permitted.

Reset
REQ-023 Reset=1 SHALL immediately, without a clock edge, force:
- state=IDLE, cur=0, Dir=1, Pend=0, both counters 0;
- hence Floor=0...01, Door=0, Moving=0.
REQ-024 Reset asserted mid-MOVE or mid-DOOR SHALL discard all pending and in-flight work; the first edge after deassertion evaluates from IDLE.

Structure
REQ-025 Package elevator_pkg SHALL hold the state enum (IDLE, MOVE, DOOR) and the Dir encoding constants.
REQ-026 Sub-module elevator_req_reg SHALL own the Pend register, clear/suppress logic, and the above/below-cur request detection, parametrised by NFLR; the FSM and counters stay in elevator_ctrl.

Verification (NFLR=4, DOOR_CYC=4, MOVE_CYC=2)
REQ-027 Reset, then Req=0001 for one cycle -> Door=1 from the next edge for exactly 4 cycles; Floor=0001; Pend stays 0000.
REQ-028 Req=1000 pulse at floor 0 -> Moving=1, Dir=1; Floor=0010, 0100, 1000 at 2-cycle spacing; then Door=1 for 4 cycles; Pend[3] clears on DOOR entry.
REQ-029 Pend=1000 while moving up from floor 0, Req=0010 before the first arrival, Req=0001 during travel:
- stop at floor 1 (Door for 4 cycles), continue to floor 3, serve it;
- then Dir=0, travel down to floor 0.
REQ-030 Blk=1 held for 6 cycles starting in the second DOOR cycle -> Door stays 1 until 4 cycles after Blk returns to 0; then IDLE.
REQ-031 Req[cur] pulsed in the last DOOR cycle -> timer reloads, Door stays 1 for 4 more cycles, Pend[cur]=0.
REQ-032 Reset pulsed between edges mid-MOVE at floor 2 -> Floor=0001, Door=0, Moving=0, Pend=0000 before the next clk edge.
